// File: rtl/ecc_pkg.sv
// Shared ECC definitions for the (71,64) Hamming-protected FIFO path.
// Codeword positions 1..71; parity bits sit at the power-of-two positions.
package ecc_pkg;

    localparam int unsigned ECC_DATA_W = 64;
    localparam int unsigned ECC_PAR_W  = 7;
    localparam int unsigned ECC_CW_W   = 71;

    localparam logic [ECC_PAR_W-1:0] ECC_PAR_POS [ECC_PAR_W] =
        '{7'd1, 7'd2, 7'd4, 7'd8, 7'd16, 7'd32, 7'd64};

    typedef enum logic [1:0] {SYN_CLEAN, SYN_CORR, SYN_UNCORR} syn_class_t;

    typedef enum logic {ST_RUN, ST_HALT} chk_state_t;

    // Codeword position of data bit idx: the idx-th non-power-of-two position.
    function automatic logic [ECC_PAR_W-1:0] ecc_data_pos(input int unsigned idx);
        int unsigned cnt;
        logic [ECC_PAR_W-1:0] pos;
        cnt = 0;
        pos = '0;
        for (int unsigned p = 1; p <= ECC_CW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p[ECC_PAR_W-1:0];
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic syn_class_t ecc_classify(input logic [ECC_PAR_W-1:0] syn,
                                                input logic is_parity_diff);
        if (syn == '0)
            return SYN_CLEAN;
        else if (is_parity_diff || syn <= 7'(ECC_CW_W))
            return SYN_CORR;
        else
            return SYN_UNCORR;
    endfunction

endpackage

// File: rtl/ecc_d64b_p7_dec.sv
// Combinational Hamming decoder: syndrome, single-bit data correction and
// a flag for syndromes that point at a parity bit.
module ecc_d64b_p7_dec
    import ecc_pkg::*;
(
    input  logic [ECC_DATA_W-1:0] data,
    input  logic [ECC_PAR_W-1:0]  parity,
    output logic [ECC_DATA_W-1:0] data_out,
    output logic [ECC_PAR_W-1:0]  syndrome,
    output logic                  is_parity_diff
);

    logic [ECC_PAR_W-1:0] contrib [ECC_DATA_W];
    logic [ECC_PAR_W-1:0] recomputed;

    // Recomputed parity is the XOR of the positions of all set data bits.
    for (genvar i = 0; i < ECC_DATA_W; i++) begin : g_bit
        localparam logic [ECC_PAR_W-1:0] POS = ecc_data_pos(i);
        assign contrib[i]  = data[i] ? POS : '0;
        assign data_out[i] = data[i] ^ (syndrome == POS);
    end

    always_comb begin
        recomputed = '0;
        for (int unsigned k = 0; k < ECC_DATA_W; k++)
            recomputed = recomputed ^ contrib[k];
    end

    assign syndrome = recomputed ^ parity;

    always_comb begin
        is_parity_diff = 1'b0;
        for (int unsigned k = 0; k < ECC_PAR_W; k++)
            if (syndrome == ECC_PAR_POS[k]) is_parity_diff = 1'b1;
    end

endmodule

// File: rtl/ecc_rd_check_pipe.sv
// Read-side ECC check: 2-stage elastic pipeline around the decoder, with
// saturating error counters, first-error log and optional halt on uncorrectable.
module ecc_rd_check_pipe
    import ecc_pkg::*;
#(
    parameter int unsigned CNT_W          = 16,
    parameter bit          STOP_ON_UNCORR = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ECC_DATA_W-1:0] s_data,
    input  logic [ECC_PAR_W-1:0]  s_parity,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ECC_DATA_W-1:0] m_data,
    output logic                  m_err_corr,
    output logic                  m_err_uncorr,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      corr_cnt,
    output logic [CNT_W-1:0]      uncorr_cnt,
    output logic                  log_valid,
    output logic [ECC_PAR_W-1:0]  log_syndrome,
    output logic                  halted
);

    logic                  a_valid;
    logic [ECC_DATA_W-1:0] a_data;
    logic [ECC_PAR_W-1:0]  a_parity;
    logic                  b_valid;
    logic [ECC_PAR_W-1:0]  b_syndrome;
    chk_state_t            state;

    logic [ECC_DATA_W-1:0] dec_data;
    logic [ECC_PAR_W-1:0]  dec_syndrome;
    logic                  dec_is_par;
    syn_class_t            dec_class;

    logic b_load, a_adv, a_take, handoff;

    ecc_d64b_p7_dec u_dec (
        .data           (a_data),
        .parity         (a_parity),
        .data_out       (dec_data),
        .syndrome       (dec_syndrome),
        .is_parity_diff (dec_is_par)
    );

    assign dec_class = ecc_classify(dec_syndrome, dec_is_par);

    assign b_load  = !b_valid || m_ready;
    assign a_adv   = a_valid && b_load;
    assign s_ready = (state == ST_RUN) && (!a_valid || a_adv);
    assign a_take  = s_valid && s_ready;
    assign handoff = b_valid && m_ready;
    assign m_valid = b_valid;
    assign halted  = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid  <= 1'b0;
            a_data   <= '0;
            a_parity <= '0;
        end else if (a_take) begin
            a_valid  <= 1'b1;
            a_data   <= s_data;
            a_parity <= s_parity;
        end else if (a_adv) begin
            a_valid  <= 1'b0;
        end
    end

    // Stage B keeps its payload when it empties so m_* stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid      <= 1'b0;
            m_data       <= '0;
            m_err_corr   <= 1'b0;
            m_err_uncorr <= 1'b0;
            b_syndrome   <= '0;
        end else if (b_load) begin
            b_valid <= a_valid;
            if (a_valid) begin
                m_data       <= (dec_class == SYN_UNCORR) ? a_data : dec_data;
                m_err_corr   <= (dec_class == SYN_CORR);
                m_err_uncorr <= (dec_class == SYN_UNCORR);
                b_syndrome   <= dec_syndrome;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_cnt     <= '0;
            uncorr_cnt   <= '0;
            log_valid    <= 1'b0;
            log_syndrome <= '0;
        end else if (handoff) begin
            if (m_err_corr && corr_cnt != '1)     corr_cnt   <= corr_cnt + 1'b1;
            if (m_err_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
            if ((m_err_corr || m_err_uncorr) && !log_valid) begin
                log_valid    <= 1'b1;
                log_syndrome <= b_syndrome;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (STOP_ON_UNCORR && handoff && m_err_uncorr && !cnt_clr)
                             state <= ST_HALT;
                ST_HALT: if (cnt_clr) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_rd_check_pipe.sv
// Self-checking bench for ecc_rd_check_pipe (CNT_W=4, STOP_ON_UNCORR=1).
module tb_ecc_rd_check_pipe;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, m_valid, m_ready, cnt_clr;
    logic [63:0] s_data, m_data;
    logic [6:0]  s_parity, log_syndrome;
    logic        m_err_corr, m_err_uncorr, log_valid, halted;
    logic [3:0]  corr_cnt, uncorr_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic        corr;
        logic        uncorr;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [63:0] dflip;
        logic [6:0]  pflip;
        logic        corr;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    ecc_rd_check_pipe #(.CNT_W(4), .STOP_ON_UNCORR(1'b1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_parity(s_parity), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_err_corr(m_err_corr), .m_err_uncorr(m_err_uncorr),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
        .log_valid(log_valid), .log_syndrome(log_syndrome), .halted(halted)
    );

    // Reference Hamming encoder: data bits fill non-power-of-two positions in order.
    function automatic logic [6:0] ecc_d64b_p7_enc(input logic [63:0] d);
        logic [6:0]  p;
        int unsigned pos;
        p   = '0;
        pos = 1;
        for (int i = 0; i < 64; i++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            for (int j = 0; j < 7; j++)
                if (pos[j]) p[j] = p[j] ^ d[i];
            pos++;
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [6:0] p, input exp_t e);
        bit ok;
        ok       = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        s_parity = p;
        sb.push_back(e);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("accept", ok, 1);
    endtask

    task automatic monitor(input int n, input int budget);
        int   got;
        exp_t e;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_err_corr", m_err_corr, e.corr);
                    check("m_err_uncorr", m_err_uncorr, e.uncorr);
                end
                got++;
            end
        end
        check("words_out", got, n);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t        e;
        logic [63:0] d;
        bit          seen;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'h0,                  7'h00, 1'b0};
        vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'h1,                  7'h00, 1'b1};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 64'h0,                  7'h01, 1'b1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  7'h00, 1'b0};
        vecs[4] = '{64'h0,                   64'h8000_0000_0000_0000, 7'h00, 1'b1};
        vecs[5] = '{64'hA5A5_A5A5_A5A5_A5A5, 64'h0,                  7'h40, 1'b1};
        vecs[6] = '{64'h8000_0001_0000_0000, 64'h0,                  7'h00, 1'b0};
        vecs[7] = '{64'hCAFE_F00D_1234_5678, 64'h8000_0000,           7'h00, 1'b1};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_parity = '0; m_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_data", m_data, 0);
        check("rst_corr_cnt", corr_cnt, 0);
        check("rst_log_valid", log_valid, 0);
        check("rst_halted", halted, 0);
        @(posedge clk);
        #1;

        // Latency: accept edge, then m_valid on the second cycle after it.
        s_valid  = 1'b1;
        s_data   = 64'h0123_4567_89AB_CDEF;
        s_parity = ecc_d64b_p7_enc(s_data);
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        check("lat_m_valid_c1", m_valid, 0);
        @(negedge clk);
        check("lat_m_valid_c2", m_valid, 1);
        check("lat_m_data", m_data, 64'h0123_4567_89AB_CDEF);
        check("lat_flags", {m_err_corr, m_err_uncorr}, 0);
        @(posedge clk);
        #1;

        // Table-driven vectors streamed back to back.
        fork
            for (int i = 0; i < 8; i++) begin
                e = '{vecs[i].data, vecs[i].corr, 1'b0};
                send(vecs[i].data ^ vecs[i].dflip,
                     ecc_d64b_p7_enc(vecs[i].data) ^ vecs[i].pflip, e);
            end
            monitor(8, 100);
        join
        settle();
        check("tbl_corr_cnt", corr_cnt, 5);
        check("tbl_uncorr_cnt", uncorr_cnt, 0);
        check("tbl_log_valid", log_valid, 1);
        check("tbl_log_syndrome", log_syndrome, 3);
        @(posedge clk);
        #1;

        // Backpressure: m_ready low for cycles 3..7 of the stream.
        fork
            for (int i = 0; i < 8; i++) begin
                d = {$urandom, $urandom};
                e = '{d, 1'b0, 1'b0};
                send(d, ecc_d64b_p7_enc(d), e);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    m_ready = !(c >= 3 && c <= 7);
                    @(negedge clk);
                    if (c == 6) begin
                        check("bp_s_ready", s_ready, 0);
                        check("bp_m_valid", m_valid, 1);
                    end
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
            monitor(8, 100);
        join
        check("bp_sb_empty", sb.size(), 0);
        settle();
        check("bp_corr_cnt", corr_cnt, 5);
        @(posedge clk);
        #1;

        // Uncorrectable word with all parity bits inverted: halt after handoff.
        d = 64'h0123_4567_89AB_CDEF;
        e = '{d, 1'b0, 1'b1};
        fork
            send(d, ~ecc_d64b_p7_enc(d), e);
            monitor(1, 20);
        join
        settle();
        check("unc_uncorr_cnt", uncorr_cnt, 1);
        check("unc_halted", halted, 1);
        check("unc_s_ready", s_ready, 0);
        check("unc_corr_cnt", corr_cnt, 5);
        @(posedge clk);
        #1;
        s_valid  = 1'b1;
        s_data   = 64'h1111_2222_3333_4444;
        s_parity = ecc_d64b_p7_enc(s_data);
        repeat (4) @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        check("halt_no_output", m_valid, 0);
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_corr_cnt", corr_cnt, 0);
        check("clr_uncorr_cnt", uncorr_cnt, 0);
        check("clr_halted", halted, 0);
        check("clr_s_ready", s_ready, 1);
        check("clr_log_valid", log_valid, 0);
        @(posedge clk);
        #1;

        // Saturation: 20 corrected words against a 4-bit counter.
        fork
            for (int i = 0; i < 20; i++) begin
                d = {$urandom, $urandom};
                e = '{d, 1'b1, 1'b0};
                send(d ^ (64'h1 << $urandom_range(63)), ecc_d64b_p7_enc(d), e);
            end
            monitor(20, 200);
        join
        settle();
        check("sat_corr_cnt", corr_cnt, 15);
        check("sat_log_valid", log_valid, 1);
        @(posedge clk);
        #1;

        // cnt_clr coincident with a corrected-word handoff: clear wins.
        d = 64'h5555_0000_AAAA_FFFF;
        e = '{d, 1'b1, 1'b0};
        send(d ^ 64'h10, ecc_d64b_p7_enc(d), e);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = m_valid;
        end
        check("coin_m_valid", seen, 1);
        cnt_clr = 1'b1;
        e = sb.pop_front();
        check("coin_m_data", m_data, e.data);
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        check("coin_corr_cnt", corr_cnt, 0);
        check("coin_log_valid", log_valid, 0);
        check("coin_m_valid_after", m_valid, 0);
        @(posedge clk);
        #1;

        // Reset mid-stream discards in-flight words.
        d = 64'hDEAD_BEEF_0BAD_F00D;
        s_valid  = 1'b1;
        s_data   = d ^ 64'h4;
        s_parity = ecc_d64b_p7_enc(d);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_m_data", m_data, 0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_output", m_valid, 0);
        check("mid_rst_corr_cnt", corr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
